// File: rtl/pifo_reg_driver.sv
// Handshake adapter between a valid/ready stream and a register-based PIFO:
// forwards inserts, pops the current minimum into a one-entry output register.
module pifo_reg_driver #(
    parameter int L2_REG_WIDTH = 2,
    parameter int RANK_WIDTH   = 8,
    parameter int META_WIDTH   = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [RANK_WIDTH-1:0] enq_rank,
    input  logic [META_WIDTH-1:0] enq_meta,

    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [RANK_WIDTH-1:0] deq_rank,
    output logic [META_WIDTH-1:0] deq_meta,

    output logic                  pifo_insert,
    output logic [RANK_WIDTH-1:0] pifo_rank_in,
    output logic [META_WIDTH-1:0] pifo_meta_in,
    output logic                  pifo_remove,
    input  logic [RANK_WIDTH-1:0] pifo_rank_out,
    input  logic [META_WIDTH-1:0] pifo_meta_out,
    input  logic                  pifo_valid_out,
    input  logic                  pifo_full,

    output logic [CNT_WIDTH-1:0]  enq_cnt,
    output logic [CNT_WIDTH-1:0]  deq_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int DEPTH = 2 ** L2_REG_WIDTH;

    if (DEPTH < 2) begin : g_depth_check
        $error("pifo_reg_driver: attached PIFO must hold at least two entries");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   pop;
    logic   rst_dly;
    logic   enq_fire;
    logic   deq_fire;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The PIFO needs the cycle after reset to settle, so popping waits for rst_dly to clear.
    always_ff @(posedge clk) begin
        rst_dly <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                pop = pifo_valid_out & (~deq_valid | deq_ready) & ~rst & ~rst_dly;
                if (pop) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Insert and remove share the PIFO command slot; a pop always wins it.
    assign enq_ready    = ~pop & ~rst;
    assign enq_fire     = enq_valid & enq_ready;
    assign deq_fire     = deq_valid & deq_ready;
    assign pifo_insert  = enq_fire;
    assign pifo_rank_in = enq_rank;
    assign pifo_meta_in = enq_meta;
    assign pifo_remove  = pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            deq_valid <= 1'b0;
            deq_rank  <= '0;
            deq_meta  <= '0;
        end else if (pop) begin
            deq_valid <= 1'b1;
            deq_rank  <= pifo_rank_out;
            deq_meta  <= pifo_meta_out;
        end else if (deq_fire) begin
            deq_valid <= 1'b0;
        end
    end

    // An insert into a full PIFO always loses exactly one packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            enq_cnt  <= '0;
            deq_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (enq_fire) begin
                enq_cnt <= sat_inc(enq_cnt);
            end
            if (deq_fire) begin
                deq_cnt <= sat_inc(deq_cnt);
            end
            if (enq_fire && pifo_full) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pifo_reg_driver.sv
// Bench for pifo_reg_driver: behavioural 4-entry PIFO plus a queue of expected dequeue ranks.
module tb_pifo_reg_driver;

    localparam int RW    = 8;
    localparam int MW    = 8;
    localparam int CW    = 4;
    localparam int L2    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq_valid;
    logic          enq_ready;
    logic [RW-1:0] enq_rank;
    logic [MW-1:0] enq_meta;
    logic          deq_valid;
    logic          deq_ready;
    logic [RW-1:0] deq_rank;
    logic [MW-1:0] deq_meta;
    logic          pifo_insert;
    logic [RW-1:0] pifo_rank_in;
    logic [MW-1:0] pifo_meta_in;
    logic          pifo_remove;
    logic [RW-1:0] pifo_rank_out;
    logic [MW-1:0] pifo_meta_out;
    logic          pifo_valid_out;
    logic          pifo_full;
    logic [CW-1:0] enq_cnt;
    logic [CW-1:0] deq_cnt;
    logic [CW-1:0] drop_cnt;

    pifo_reg_driver #(
        .L2_REG_WIDTH(L2),
        .RANK_WIDTH  (RW),
        .META_WIDTH  (MW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enq_valid     (enq_valid),
        .enq_ready     (enq_ready),
        .enq_rank      (enq_rank),
        .enq_meta      (enq_meta),
        .deq_valid     (deq_valid),
        .deq_ready     (deq_ready),
        .deq_rank      (deq_rank),
        .deq_meta      (deq_meta),
        .pifo_insert   (pifo_insert),
        .pifo_rank_in  (pifo_rank_in),
        .pifo_meta_in  (pifo_meta_in),
        .pifo_remove   (pifo_remove),
        .pifo_rank_out (pifo_rank_out),
        .pifo_meta_out (pifo_meta_out),
        .pifo_valid_out(pifo_valid_out),
        .pifo_full     (pifo_full),
        .enq_cnt       (enq_cnt),
        .deq_cnt       (deq_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [RW-1:0] exp_q[$];
    logic          pifo_clr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] meta_of(input logic [RW-1:0] r);
        return r ^ 8'h5A;
    endfunction

    // Sorted register PIFO: min at index 0, evicts the max when full, and its
    // output is invalid for one cycle after any insert or remove.
    logic [RW-1:0] m_rank[DEPTH];
    logic [MW-1:0] m_meta[DEPTH];
    int            m_cnt  = 0;
    logic          m_busy = 1'b0;
    logic [RW-1:0] t_rank[DEPTH];
    logic [MW-1:0] t_meta[DEPTH];
    int            t_cnt;
    int            p;

    always @(posedge clk) begin
        t_rank = m_rank;
        t_meta = m_meta;
        t_cnt  = m_cnt;
        if (pifo_clr) begin
            t_cnt = 0;
            m_busy <= 1'b0;
        end else if (pifo_insert) begin
            if (t_cnt == DEPTH && pifo_rank_in < t_rank[DEPTH-1]) t_cnt = DEPTH - 1;
            if (t_cnt < DEPTH) begin
                p = t_cnt;
                while (p > 0 && t_rank[p-1] > pifo_rank_in) begin
                    t_rank[p] = t_rank[p-1];
                    t_meta[p] = t_meta[p-1];
                    p--;
                end
                t_rank[p] = pifo_rank_in;
                t_meta[p] = pifo_meta_in;
                t_cnt++;
            end
            m_busy <= 1'b1;
        end else if (pifo_remove) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                t_rank[i] = t_rank[i+1];
                t_meta[i] = t_meta[i+1];
            end
            t_cnt--;
            m_busy <= 1'b1;
        end else begin
            m_busy <= 1'b0;
        end
        m_rank <= t_rank;
        m_meta <= t_meta;
        m_cnt  <= t_cnt;
    end

    assign pifo_valid_out = (m_cnt != 0) && !m_busy;
    assign pifo_rank_out  = m_rank[0];
    assign pifo_meta_out  = m_meta[0];
    assign pifo_full      = (m_cnt == DEPTH);

    // Scoreboard: each accepted dequeue pops the next expected rank.
    always @(negedge clk) begin
        if (!rst && deq_valid && deq_ready) begin
            if (exp_q.size() == 0) begin
                chk("deq_unexpected", {24'd0, deq_rank}, 32'hFFFF_FFFF);
            end else begin
                chk("deq_rank", {24'd0, deq_rank}, {24'd0, exp_q[0]});
                chk("deq_meta", {24'd0, deq_meta}, {24'd0, meta_of(exp_q[0])});
                void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) chk("insert_remove_excl", {31'd0, pifo_insert & pifo_remove}, 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        pifo_clr  = 1'b1;
        enq_valid = 1'b1;
        enq_rank  = 8'h33;
        enq_meta  = 8'h44;
        deq_ready = 1'b0;
        step();
        @(negedge clk);
        chk("rst_enq_ready", {31'd0, enq_ready}, 32'd0);
        chk("rst_insert", {31'd0, pifo_insert}, 32'd0);
        chk("rst_remove", {31'd0, pifo_remove}, 32'd0);
        step();
        rst       = 1'b0;
        pifo_clr  = 1'b0;
        enq_valid = 1'b0;
        @(negedge clk);
        chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("rst_deq_rank", {24'd0, deq_rank}, 32'd0);
        chk("rst_enq_cnt", {28'd0, enq_cnt}, 32'd0);
        chk("rst_deq_cnt", {28'd0, deq_cnt}, 32'd0);
        chk("rst_drop_cnt", {28'd0, drop_cnt}, 32'd0);
        step();
    endtask

    task automatic send(input logic [RW-1:0] r);
        int n;
        n         = 0;
        enq_valid = 1'b1;
        enq_rank  = r;
        enq_meta  = meta_of(r);
        @(negedge clk);
        while (!enq_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("enq_accept", {31'd0, enq_ready}, 32'd1);
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_done", exp_q.size(), 32'd0);
        repeat (3) step();
    endtask

    task automatic chk_cnts(input string tag, input int e, input int d, input int x);
        chk({tag, "_enq_cnt"}, {28'd0, enq_cnt}, e);
        chk({tag, "_deq_cnt"}, {28'd0, deq_cnt}, d);
        chk({tag, "_drop_cnt"}, {28'd0, drop_cnt}, x);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] r;
        rst       = 1'b1;
        pifo_clr  = 1'b1;
        enq_valid = 1'b0;
        enq_rank  = '0;
        enq_meta  = '0;
        deq_ready = 1'b0;

        // Ordering: 5,2,7 leave as 2,5,7; output held while stalled.
        reset_dut();
        send(8'd5);
        send(8'd2);
        send(8'd7);
        exp_q.push_back(8'd2);
        exp_q.push_back(8'd5);
        exp_q.push_back(8'd7);
        repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, deq_valid}, 32'd1);
            chk("hold_rank", {24'd0, deq_rank}, 32'd2);
            chk("hold_remove", {31'd0, pifo_remove}, 32'd0);
            step();
        end
        deq_ready = 1'b1;
        @(negedge clk);
        chk("b2b_remove", {31'd0, pifo_remove}, 32'd1);
        step();
        drain();
        chk_cnts("order", 3, 3, 0);

        // Overflow: fifth insert into a full PIFO evicts the max.
        reset_dut();
        send(8'd9);
        send(8'd8);
        send(8'd7);
        send(8'd6);
        chk("pifo_full", {31'd0, pifo_full}, 32'd1);
        send(8'd1);
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd6);
        exp_q.push_back(8'd7);
        exp_q.push_back(8'd8);
        repeat (3) step();
        deq_ready = 1'b1;
        drain();
        chk_cnts("full", 5, 4, 1);

        // Pop takes priority over a waiting enqueue; it is accepted in WAIT.
        reset_dut();
        deq_ready = 1'b1;
        send(8'd3);
        exp_q.push_back(8'd3);
        step();
        enq_valid = 1'b1;
        enq_rank  = 8'd4;
        enq_meta  = meta_of(8'd4);
        @(negedge clk);
        chk("prio_remove", {31'd0, pifo_remove}, 32'd1);
        chk("prio_enq_ready", {31'd0, enq_ready}, 32'd0);
        chk("prio_insert", {31'd0, pifo_insert}, 32'd0);
        step();
        @(negedge clk);
        chk("wait_enq_ready", {31'd0, enq_ready}, 32'd1);
        chk("wait_insert", {31'd0, pifo_insert}, 32'd1);
        chk("pop_latency_valid", {31'd0, deq_valid}, 32'd1);
        step();
        enq_valid = 1'b0;
        exp_q.push_back(8'd4);
        drain();
        chk_cnts("prio", 2, 2, 0);

        // Counter saturation with 20 enqueue/dequeue pairs.
        reset_dut();
        deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom_range(0, 255));
            send(r);
            exp_q.push_back(r);
            repeat (4) step();
        end
        drain();
        chk_cnts("sat", 15, 15, 0);

        // Reset in WAIT with an entry pending discards it; no pop right after.
        reset_dut();
        send(8'd10);
        send(8'd20);
        step();
        @(negedge clk);
        chk("mid_pop", {31'd0, pifo_remove}, 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pending", {31'd0, deq_valid}, 32'd1);
        chk("mid_rst_remove", {31'd0, pifo_remove}, 32'd0);
        chk("mid_rst_enq_ready", {31'd0, enq_ready}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("post_rst_remove", {31'd0, pifo_remove}, 32'd0);
        chk_cnts("post_rst", 0, 0, 0);
        step();
        exp_q.push_back(8'd20);
        @(negedge clk);
        chk("post_rst_pop", {31'd0, pifo_remove}, 32'd1);
        step();
        deq_ready = 1'b1;
        drain();
        chk_cnts("resume", 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pifo_reg_driver.md
PIFO_REG_DRIVER -- requirements
Module: pifo_reg_driver

Interface
REQ-001 SHALL have parameter L2_REG_WIDTH, default 2, meaning log2 of the attached PIFO register depth (DEPTH = 2**L2_REG_WIDTH).
REQ-002 SHALL have parameter RANK_WIDTH, default 8, meaning rank bits.
REQ-003 SHALL have parameter META_WIDTH, default 8, meaning metadata bits.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning statistics counter bits.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 enq_valid / enq_ready / enq_rank / enq_meta  in / out / in / in  1 / 1 / RANK_WIDTH / META_WIDTH  upstream enqueue port.
REQ-008 deq_valid / deq_ready / deq_rank / deq_meta  out / in / out / out  1 / 1 / RANK_WIDTH / META_WIDTH  downstream dequeue port.
REQ-009 pifo_insert / pifo_rank_in / pifo_meta_in  out  1 / RANK_WIDTH / META_WIDTH  PIFO insert command and data.
REQ-010 pifo_remove  out  1  PIFO remove-minimum command.
REQ-011 pifo_rank_out / pifo_meta_out / pifo_valid_out  in  RANK_WIDTH / META_WIDTH / 1  PIFO current minimum and its valid flag.
REQ-012 pifo_full  in  1  PIFO full flag.
REQ-013 enq_cnt / deq_cnt / drop_cnt  out  CNT_WIDTH each  statistics.

Function
REQ-014 enq fire = enq_valid & enq_ready; deq fire = deq_valid & deq_ready.
REQ-015 pifo_insert SHALL equal enq fire, combinationally; pifo_rank_in/pifo_meta_in SHALL pass through enq_rank/enq_meta.
REQ-016 FSM states: IDLE, WAIT.
REQ-017 pop condition: state==IDLE & pifo_valid_out & (!deq_valid | deq_ready).
REQ-018 pifo_remove SHALL equal pop condition, combinationally.
REQ-019 enq_ready SHALL equal !pop condition & !rst; pifo_insert and pifo_remove never high in the same cycle; enq_ready independent of enq_valid.
REQ-020 On pop: deq_rank/deq_meta <= pifo_rank_out/pifo_meta_out, deq_valid <= 1, state <= WAIT.
REQ-021 WAIT: one cycle, no pop; enqueue permitted; next state IDLE unconditionally.
REQ-022 Deq output register: deq fire without pop clears deq_valid; deq fire with pop reloads (back-to-back, no bubble on output side).
REQ-023 deq_rank/deq_meta SHALL hold stable while deq_valid & !deq_ready.
REQ-024 Pop latency: pifo_valid_out rising in IDLE with output free -> deq_valid high next cycle.
REQ-025 Sustained throughput: at most one pop per 3 cycles (pop, WAIT, PIFO re-evaluation cycle with pifo_valid_out low).
REQ-026 enq_cnt increments on enq fire; deq_cnt on deq fire; drop_cnt on enq fire with pifo_full=1 (new entry dropped or max evicted: one packet lost).
REQ-027 All counters saturate at 2**CNT_WIDTH-1; no wrap.
REQ-028 Empty PIFO (pifo_valid_out=0): no pop; deq_valid drains normally.
REQ-029 Full PIFO: enq_ready unaffected; insert still issued; drop_cnt rule REQ-026 applies.

Reset
REQ-030 On rst: state IDLE, deq_valid 0, deq_rank 0, deq_meta 0, all counters 0.
REQ-031 During rst: pifo_insert 0, pifo_remove 0, enq_ready 0.
REQ-032 rst mid-operation (WAIT or deq_valid pending) SHALL discard the held entry; no pop on the reset cycle or the cycle after.

Verification
REQ-033 Enqueue ranks 5,2,7 (one per cycle, deq_ready=0), then deq_ready=1 -> deq_rank sequence 2,5,7; enq_cnt=3, deq_cnt=3, drop_cnt=0.
REQ-034 DEPTH=4, enqueue ranks 9,8,7,6,1 -> drop_cnt=1; drain yields 1,6,7,8.
REQ-035 pifo_valid_out=1 in IDLE with enq_valid=1 -> pifo_remove=1, enq_ready=0, pifo_insert=0 that cycle; enqueue accepted in WAIT.
REQ-036 deq_ready held 0 for 10 cycles with entry pending -> deq_rank stable, pifo_remove=0 throughout; deq_ready=1 -> next entry loaded same edge.
REQ-037 CNT_WIDTH=4, 20 enqueue/dequeue pairs -> enq_cnt=deq_cnt=15.
REQ-038 rst asserted in WAIT with deq_valid=1 -> next cycle deq_valid=0, counters 0, state IDLE.
